// File: rtl/dds_lut_loader.sv
// dds_lut_loader: streams LUT_DEPTH waveform bytes from a valid/ready host
// stream into a DDS core's LUT write port, then hands the phase step through.
//
// Sequence: IDLE -> REWIND (step_out=1 for one cycle returns the DDS LUT write
// address to 0) -> LOAD (one cfg_ce write per accepted byte) -> [CHECK] -> RUN.
// A load that stalls for STALL_TIMEOUT cycles aborts to IDLE with sticky err.
//
// Optional feature: define DDS_LUT_LOADER_CHECKSUM_EN to add the CHECK state,
// which consumes one extra byte. The mod-256 sum of all data bytes plus that
// byte must be 0x00, otherwise the load fails with err.
//
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start              pulse: begin a new load (honoured in IDLE and RUN only)
//   s_data/s_valid     host byte stream;  s_ready: loader accepts a byte
//   step_in            user phase step, forwarded in RUN with 1-cycle latency
//   cfg/cfg_ce         LUT write byte and strobe to the DDS
//   step_out           phase step to the DDS
//   busy               high in REWIND, LOAD and CHECK
//   done               one-cycle pulse on entry to RUN
//   err                sticky load failure, cleared by an accepted start
module dds_lut_loader #(
  parameter int unsigned LUT_DEPTH     = 4096,
  parameter int unsigned STALL_TIMEOUT = 65535
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  s_data,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] step_in,
  output logic [7:0]  cfg,
  output logic        cfg_ce,
  output logic [31:0] step_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int unsigned CNT_W   = 12;
  localparam int unsigned STALL_W = 16;
  localparam int unsigned DATA_W  = 8;
  localparam int unsigned STEP_W  = 32;

  localparam logic [CNT_W-1:0]   LAST_BEAT  = CNT_W'(LUT_DEPTH - 1);
  localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_TIMEOUT - 1);

`ifdef DDS_LUT_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_LOAD, S_CHECK, S_RUN
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_REWIND, S_LOAD, S_RUN
  } state_t;
`endif

  state_t              state, state_d;
  logic [CNT_W-1:0]    byte_cnt, byte_cnt_d;
  logic [STALL_W-1:0]  stall_cnt, stall_cnt_d;
  logic [DATA_W-1:0]   cfg_d;
  logic                cfg_ce_d;
  logic                s_ready_d;
  logic [STEP_W-1:0]   step_out_d;
  logic                busy_d;
  logic                done_d;
  logic                err_d;
  logic                beat_c;
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
  logic [DATA_W-1:0]   sum, sum_d;
`endif

  assign beat_c = s_valid & s_ready;

  // Next state, counters and next values of every registered output.
  always_comb begin
    state_d     = state;
    byte_cnt_d  = byte_cnt;
    stall_cnt_d = stall_cnt;
    cfg_d       = cfg;
    cfg_ce_d    = 1'b0;
    err_d       = err;
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
    sum_d       = sum;
`endif

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_REWIND;
          err_d   = 1'b0;
        end
      end

      S_REWIND: begin
        byte_cnt_d  = '0;
        stall_cnt_d = '0;
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
        sum_d       = '0;
`endif
        state_d     = S_LOAD;
      end

      S_LOAD: begin
        if (beat_c) begin
          cfg_d       = s_data;
          cfg_ce_d    = 1'b1;
          stall_cnt_d = '0;
          byte_cnt_d  = byte_cnt + CNT_W'(1);
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
          sum_d       = sum + s_data;
          if (byte_cnt == LAST_BEAT) state_d = S_CHECK;
`else
          if (byte_cnt == LAST_BEAT) state_d = S_RUN;
`endif
        end else if (stall_cnt == STALL_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt + STALL_W'(1);
        end
      end

`ifdef DDS_LUT_LOADER_CHECKSUM_EN
      // The checksum byte is consumed but never written to the LUT.
      S_CHECK: begin
        if (beat_c) begin
          stall_cnt_d = '0;
          if (DATA_W'(sum + s_data) == '0) begin
            state_d = S_RUN;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end else if (stall_cnt == STALL_LAST) begin
          state_d = S_IDLE;
          err_d   = 1'b1;
        end else begin
          stall_cnt_d = stall_cnt + STALL_W'(1);
        end
      end
`endif

      S_RUN: begin
        if (start) begin
          state_d = S_REWIND;
          err_d   = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with it.
    s_ready_d  = 1'b0;
    busy_d     = 1'b0;
    step_out_d = '0;
    case (state_d)
      S_REWIND: begin
        busy_d     = 1'b1;
        step_out_d = STEP_W'(1);
      end
      S_LOAD: begin
        busy_d    = 1'b1;
        s_ready_d = 1'b1;
      end
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
      S_CHECK: begin
        busy_d    = 1'b1;
        s_ready_d = 1'b1;
      end
`endif
      S_RUN:   step_out_d = step_in;
      default: ;
    endcase
    done_d = (state_d == S_RUN) && (state != S_RUN);
  end

  // State, counters and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      byte_cnt  <= '0;
      stall_cnt <= '0;
      cfg       <= '0;
      cfg_ce    <= 1'b0;
      s_ready   <= 1'b0;
      step_out  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else begin
      state     <= state_d;
      byte_cnt  <= byte_cnt_d;
      stall_cnt <= stall_cnt_d;
      cfg       <= cfg_d;
      cfg_ce    <= cfg_ce_d;
      s_ready   <= s_ready_d;
      step_out  <= step_out_d;
      busy      <= busy_d;
      done      <= done_d;
      err       <= err_d;
`ifdef DDS_LUT_LOADER_CHECKSUM_EN
      sum       <= sum_d;
`endif
    end
  end

endmodule

// File: tb/tb_dds_lut_loader.sv
// Self-checking bench for dds_lut_loader: directed sequence of loads with
// sequential, toggled and random streams, stall abort, mid-load reset, start
// filtering and (when DDS_LUT_LOADER_CHECKSUM_EN is defined) checksum checks.
module tb_dds_lut_loader;

  localparam int unsigned DEPTH = 4096;
  localparam int unsigned STALL = 300;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] step_in;
  logic [7:0]  cfg;
  logic        cfg_ce;
  logic [31:0] step_out;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_data [DEPTH];

  dds_lut_loader #(.LUT_DEPTH(DEPTH), .STALL_TIMEOUT(STALL)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .s_data   (s_data),
    .s_valid  (s_valid),
    .s_ready  (s_ready),
    .step_in  (step_in),
    .cfg      (cfg),
    .cfg_ce   (cfg_ce),
    .step_out (step_out),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_b(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_w(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_w({tag, "_step"}, step_out, 32'h0);
    chk_w({tag, "_cfg"}, 32'(cfg), 32'h0);
    chk_b({tag, "_cfg_ce"}, cfg_ce, 1'b0);
    chk_b({tag, "_ready"}, s_ready, 1'b0);
    chk_b({tag, "_busy"}, busy, 1'b0);
    chk_b({tag, "_done"}, done, 1'b0);
    chk_b({tag, "_err"}, err, 1'b0);
  endtask

  // One full load. vmode: 0 seq/always valid, 1 seq/toggled valid,
  // 2 random data/random valid, 3 all 0x01/always valid.
  task automatic do_load(input int vmode, input bit start_in_load, input bit bad_ck);
    int         beats;
    int         cyc_cnt;
    bit         acc;
    logic [7:0] sum;
    logic [7:0] last_cfg;
    logic [31:0] step_v;
    beats   = 0;
    cyc_cnt = 0;
    sum     = 8'h00;
    for (int i = 0; i < int'(DEPTH); i++) begin
      case (vmode)
        2:       exp_data[i] = 8'($urandom);
        3:       exp_data[i] = 8'h01;
        default: exp_data[i] = 8'(i);
      endcase
    end

    step_in = (vmode == 0) ? 32'h0010_0000 : $urandom;
    s_valid = 1'b0;
    start   = 1'b1;
    tick();
    start = 1'b0;
    chk_w("rewind_step", step_out, 32'h1);
    chk_b("rewind_busy", busy, 1'b1);
    chk_b("rewind_ready", s_ready, 1'b0);
    chk_b("rewind_cfg_ce", cfg_ce, 1'b0);
    chk_b("rewind_err", err, 1'b0);
    tick();
    chk_w("load_step0", step_out, 32'h0);
    last_cfg = cfg;

    while (beats < int'(DEPTH) && cyc_cnt < 4 * int'(DEPTH) + 100) begin
      case (vmode)
        1:       s_valid = 1'((cyc_cnt % 2) == 0);
        2:       s_valid = 1'($urandom_range(0, 3) != 0);
        default: s_valid = 1'b1;
      endcase
      s_data = s_valid ? exp_data[beats] : 8'($urandom);
      start  = start_in_load && s_valid && (beats == 50 || beats == int'(DEPTH) - 1);
      chk_b("load_ready", s_ready, 1'b1);
      acc = s_valid && s_ready;
      tick();
      cyc_cnt++;
      start = 1'b0;
      chk_b("load_cfg_ce", cfg_ce, acc);
      if (acc) begin
        chk_w("load_cfg", 32'(cfg), 32'(exp_data[beats]));
        last_cfg = exp_data[beats];
        sum      = sum + exp_data[beats];
        beats++;
      end else begin
        chk_w("load_cfg_hold", 32'(cfg), 32'(last_cfg));
      end
      if (beats < int'(DEPTH)) begin
        chk_w("load_step", step_out, 32'h0);
        chk_b("load_busy", busy, 1'b1);
        chk_b("load_done", done, 1'b0);
      end
    end
    s_valid = 1'b0;
    chk_w("load_beats", 32'(beats), 32'(DEPTH));

`ifdef DDS_LUT_LOADER_CHECKSUM_EN
    chk_b("check_ready", s_ready, 1'b1);
    s_data  = bad_ck ? 8'(8'h00 - sum + 8'h01) : 8'(8'h00 - sum);
    s_valid = 1'b1;
    tick();
    s_valid = 1'b0;
    chk_b("check_cfg_ce", cfg_ce, 1'b0);
    chk_w("check_cfg_hold", 32'(cfg), 32'(last_cfg));
    if (bad_ck) begin
      chk_b("ck_bad_err", err, 1'b1);
      chk_b("ck_bad_done", done, 1'b0);
      chk_b("ck_bad_busy", busy, 1'b0);
      chk_b("ck_bad_ready", s_ready, 1'b0);
      chk_w("ck_bad_step", step_out, 32'h0);
      return;
    end
`else
    if (bad_ck) chk_b("bad_ck_unused", 1'b0, 1'b0 ^ bad_ck ^ bad_ck);
`endif

    chk_b("run_done", done, 1'b1);
    chk_b("run_ready", s_ready, 1'b0);
    chk_b("run_busy", busy, 1'b0);
    chk_b("run_err", err, 1'b0);
    chk_w("run_step", step_out, step_in);
    tick();
    chk_b("run_done_pulse", done, 1'b0);
    chk_b("run_no_write", cfg_ce, 1'b0);
    step_v  = $urandom;
    step_in = step_v;
    tick();
    chk_w("run_step_rand", step_out, step_v);
    step_in = 32'h0;
    tick();
    chk_w("run_step_zero", step_out, 32'h0);
  endtask

  initial begin
    reset   = 1'b1;
    start   = 1'b0;
    s_valid = 1'b0;
    s_data  = 8'h00;
    step_in = 32'h0;
    tick();
    tick();
    chk_idle_outputs("reset");
    reset = 1'b0;
    tick();
    chk_idle_outputs("idle");

    // Sequential stream, toggled valid, random stream with start pulses in LOAD.
    do_load(0, 1'b0, 1'b0);
    do_load(1, 1'b0, 1'b0);
    do_load(2, 1'b1, 1'b0);
    // Restart from RUN with start also coincident with the final beat.
    do_load(0, 1'b1, 1'b0);

    // Stall after 100 beats.
    step_in = 32'h1234_5678;
    start   = 1'b1;
    tick();
    start = 1'b0;
    tick();
    for (int i = 0; i < 100; i++) begin
      s_valid = 1'b1;
      s_data  = 8'(i);
      tick();
    end
    chk_b("stall_last_beat", cfg_ce, 1'b1);
    s_valid = 1'b0;
    for (int k = 1; k <= int'(STALL); k++) begin
      tick();
      if (k == int'(STALL) - 1) begin
        chk_b("stall_early_err", err, 1'b0);
        chk_b("stall_early_busy", busy, 1'b1);
      end
    end
    chk_b("stall_err", err, 1'b1);
    chk_b("stall_busy", busy, 1'b0);
    chk_b("stall_ready", s_ready, 1'b0);
    chk_w("stall_step", step_out, 32'h0);
    tick();
    chk_b("stall_err_sticky", err, 1'b1);

    // Restart after the stall, then reset at beat 2000.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk_w("restart_rewind", step_out, 32'h1);
    chk_b("restart_err_clr", err, 1'b0);
    tick();
    for (int i = 0; i < 1999; i++) begin
      s_valid = 1'b1;
      s_data  = 8'($urandom);
      tick();
    end
    chk_b("pre_reset_cfg_ce", cfg_ce, 1'b1);
    s_valid = 1'b1;
    s_data  = 8'hA5;
    reset   = 1'b1;
    tick();
    chk_idle_outputs("midload_reset");
    // Reset wins over start and s_valid in the same cycle.
    start = 1'b1;
    tick();
    chk_idle_outputs("reset_prio");
    start   = 1'b0;
    s_valid = 1'b0;
    reset   = 1'b0;
    tick();
    chk_idle_outputs("post_reset");

`ifdef DDS_LUT_LOADER_CHECKSUM_EN
    do_load(3, 1'b0, 1'b0);
    do_load(3, 1'b0, 1'b1);
    step_in = $urandom;
    tick();
    tick();
    chk_w("ck_fail_step_hold", step_out, 32'h0);
    chk_b("ck_fail_err_hold", err, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
